imem_loader: RTL and testbench

- Program loader: the writer side of the instruction memory that PC/inst_mem read from.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit instruction words.
- Writes each word to consecutive word-aligned addresses from BASE_ADDR, holding the core in reset until the image is complete.
- Sits between the host link (UART receiver or bench) and the instruction-memory write port.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 39 +++
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Checksum support is selected with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: inserts four bytes into a 32-bit word.
// word_full pulses on the handshake that supplies the fourth byte.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] word_nxt,
  output logic        word_full
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word;
  logic [1:0]  idx;

  always_comb begin
    word_nxt = word;
    word_nxt[{idx, 3'b000} +: 8] = data;
    word_full = en && (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (en) begin
      word <= word_nxt;
      idx  <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into words, writes instruction
// memory from BASE_ADDR and holds the core in reset until complete.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_WORDS);

  state_t           state, state_d;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] word_idx;
  logic [CNT_W-1:0] len_c;
  logic             start_ok;
  logic             pk_en;
  logic             word_full;
  logic [31:0]      word_nxt;
  logic             last_word;

  assign len_c     = (len_words > MAX_L) ? MAX_L : len_words;
  assign last_word = (word_idx + CNT_W'(1)) == len;
  assign pk_en     = (state == RECV) && byte_valid;

  byte_packer u_pack (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .en        (pk_en),
    .data      (byte_data),
    .word_nxt  (word_nxt),
    .word_full (word_full)
  );

  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = (len_words == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (word_full) state_d = WRITE;
      end
      WRITE: begin
        if (!last_word) state_d = RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else state_d = CHECK;
`else
        else state_d = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (byte_valid) state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      len       <= '0;
      word_idx  <= '0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
    end else begin
      state <= state_d;
      if (start_ok) begin
        len      <= len_c;
        word_idx <= '0;
      end
      // Address and data are registered as the word completes, so they
      // are stable through the WRITE cycle and hold afterwards.
      if (word_full) begin
        mem_addr  <= BASE_ADDR
                   + 32'(word_idx) * 32'(BYTES_PER_WORD);
        mem_wdata <= word_nxt;
      end
      if (state == WRITE) word_idx <= word_idx + CNT_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        csum  <= '0;
        err_q <= 1'b0;
      end else if (pk_en) begin
        csum <= csum ^ byte_data;
      end
      if (state == CHECK && byte_valid)
        err_q <= (byte_data != csum);
    end
  end

  assign err        = err_q;
  assign byte_ready = (state == RECV) || (state == CHECK);
  assign busy       = (state == RECV) || (state == WRITE)
                   || (state == CHECK);
`else
  assign err        = 1'b0;
  assign byte_ready = (state == RECV);
  assign busy       = (state == RECV) || (state == WRITE);
`endif

  assign mem_we   = (state == WRITE);
  assign done     = (state == DONE);
  assign core_rst = (state == DONE) && !err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
// Define IMEM_LOADER_CHECKSUM_EN to also exercise the checksum path.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  len_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, core_rst, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  ck = '0;
  bit          toggle = 1'b0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] wr[$];

  imem_loader #(
    .BASE_ADDR (32'h0000_0000),
    .MAX_WORDS (256),
    .CNT_W     (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_words  (len_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
      wr.push_back({31'd0, byte_ready});
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$],
                                     input int i);
    if (i < q.size()) return q[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wr.delete();
  endtask

  task automatic do_start(input logic [8:0] n);
    byte_valid = 1'b0;
    len_words  = n;
    start      = 1'b1;
    step();
    start = 1'b0;
    ck    = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    byte_valid = 1'b1;
    byte_data  = b;
    k = 0;
    while (!byte_ready && k < 20) begin
      step();
      k++;
    end
    if (!byte_ready) check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    step();
    ck = ck ^ b;
    if (toggle) begin
      byte_valid = 1'b0;
      step();
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int j = 0; j < 4; j++) send_byte(w[8*j +: 8]);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 3000) begin
      step();
      k++;
    end
    check("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic finish_img();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(ck);
`endif
    byte_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    // Reset state
    step();
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_core", {31'd0, core_rst}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    step();

    // Two-word load, byte_valid held high
    clear_log();
    do_start(9'd2);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready", {31'd0, byte_ready}, 32'd1);
    send_word(32'h0050_0013);
    check("t1_we_lat", {31'd0, mem_we}, 32'd1);
    send_word(32'h0010_0093);
    finish_img();
    check("t1_nwr", wa.size(), 32'd2);
    check("t1_a0", at(wa, 0), 32'h0);
    check("t1_d0", at(wd, 0), 32'h0050_0013);
    check("t1_a1", at(wa, 1), 32'h4);
    check("t1_d1", at(wd, 1), 32'h0010_0093);
    check("t1_core", {31'd0, core_rst}, 32'd1);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // One-word load with byte_valid toggling; restart from DONE
    clear_log();
    do_start(9'd1);
    check("t2_core_hold", {31'd0, core_rst}, 32'd0);
    toggle = 1'b1;
    send_word(32'hDEAD_BEEF);
    toggle = 1'b0;
    finish_img();
    check("t2_nwr", wa.size(), 32'd1);
    check("t2_a0", at(wa, 0), 32'h0);
    check("t2_d0", at(wd, 0), 32'hDEAD_BEEF);
    check("t2_ready_wr", at(wr, 0), 32'd0);

    // Zero-length image
    clear_log();
    do_start(9'd0);
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    check("t3_nwr", wa.size(), 32'd0);

    // Oversize request is clamped to 256 words
    clear_log();
    do_start(9'd300);
    for (int i = 0; i < 256; i++) send_word(32'(i));
    finish_img();
    step();
    step();
    check("t4_nwr", wa.size(), 32'd256);
    check("t4_last_a", at(wa, 255), 32'h3FC);
    check("t4_last_d", at(wd, 255), 32'hFF);
    check("t4_mid_d", at(wd, 128), 32'h80);

    // Reset in the middle of the second word
    do_start(9'd2);
    send_word(32'h4433_2211);
    send_byte(8'h55);
    send_byte(8'h66);
    byte_valid = 1'b0;
    clear_log();
    rst = 1'b0;
    #1;
    check("t5_we", {31'd0, mem_we}, 32'd0);
    check("t5_addr", mem_addr, 32'h0);
    check("t5_wdata", mem_wdata, 32'h0);
    check("t5_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    step();
    rst = 1'b1;
    step();
    check("t5_nowr", wa.size(), 32'd0);
    do_start(9'd1);
    send_word(32'h0403_0201);
    finish_img();
    check("t5_nwr", wa.size(), 32'd1);
    check("t5_a0", at(wa, 0), 32'h0);
    check("t5_d0", at(wd, 0), 32'h0403_0201);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Correct checksum
    do_start(9'd1);
    send_word(32'h0050_0013);
    send_byte(8'h43);
    byte_valid = 1'b0;
    wait_done();
    check("ck_ok_err", {31'd0, err}, 32'd0);
    check("ck_ok_core", {31'd0, core_rst}, 32'd1);

    // Wrong checksum
    do_start(9'd1);
    send_word(32'h0050_0013);
    send_byte(8'h42);
    byte_valid = 1'b0;
    wait_done();
    check("ck_bad_err", {31'd0, err}, 32'd1);
    check("ck_bad_core", {31'd0, core_rst}, 32'd0);

    // err clears on the next start
    do_start(9'd1);
    check("ck_err_clr", {31'd0, err}, 32'd0);
    send_word(32'h0);
    send_byte(8'h00);
    byte_valid = 1'b0;
    wait_done();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
